demo_part_sequencer: RTL and testbench
======================================

# demo_part_sequencer

Frame-rate scheduler for the racing-the-beam demo. It owns the per-part frame counter and the demo part index that select visual modes in the pixel datapath. It derives beat timing (envelope, beat index, beats-1/3 flag) and a 2-bit fade level for the colour output stage. It sequences the parts, fades between them, and accepts a debounced-free "skip" request and a "hold" freeze from the dedicated inputs.

## Interface
- `FADE_STEP`, default 2: frames per fade level; legal range 1..8.
- `START_PART`, default 0: part loaded at reset and after wrap.
- `LAST_PART`, default 7: the part after LAST_PART is START_PART. Requires START_PART ≤ LAST_PART ≤ 7.
- `clk` in 1: pixel clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `frame_start` in 1: one-cycle pulse at pixel (0,0) from the sync generator.
- `skip` in 1: asynchronous level input from a button; its rising edge requests the next part.
- `hold` in 1: while high, all frame-rate state is frozen.
- `part` out 3: current part index.
- `frame` out 7: frame count within the part, 0..127.
- `beat` out 3: equals `frame[6:4]`.
- `envelope` out 5: 31 − 2·`frame[3:0]`.
- `beats_1_3` out 1: `frame[5:4]` == 2'b10.
- `fade` out 2: brightness level; 0 = black, 3 = full.
- `part_start` out 1: one-cycle pulse in the cycle after a part advance.

## Operation
- **Reset values:** `part`=START_PART, `frame`=0, `fade`=0, `part_start`=0, state=WAIT, skip pending flag cleared, step counter `sc`=0.
- **Skip input path:** 2-flop synchronizer, then a rising-edge detector. A detected edge sets the `pend` flag. `pend` is cleared at every frame_start that is not ignored by hold, whether the skip is honoured or not.
- **Frame event:** a cycle with `frame_start`=1 and `hold`=0. Nothing else changes frame-rate state. When `hold`=1, frame_start is ignored and `pend` is retained.
- **Frame counter:** increments by 1 on every frame event and wraps 127→0. A wrap always forces a part advance.
- **Fade step counter:** `sc` counts frame events 0..FADE_STEP−1 and is reset to 0 on every state entry. A "step expiry" is a frame event with `sc`==FADE_STEP−1.
- **States:**
  - **WAIT:** on the first frame event, go to FADE_IN with `fade`=0. `frame` is not incremented on this event.
  - **FADE_IN:** on each step expiry, `fade` increments; when it reaches 3, go to RUN.
  - **RUN:** holds `fade`=3.
  - **FADE_OUT:** on each step expiry, `fade` decrements. A step expiry with `fade`==0 triggers an advance.
- **Entering FADE_OUT:** from RUN or FADE_IN, at a frame event where `pend`=1 or the next `frame` equals 128−4·FADE_STEP. `fade` is kept at its current value. In FADE_OUT, `pend` is ignored.
- **Advance:**
  - `part` ← `part`==LAST_PART ? START_PART : `part`+1.
  - `frame` ← 0, `fade` ← 0, state ← FADE_IN, `part_start`=1 for one cycle.
  - A natural run gives 4·FADE_STEP fade-out frames at levels 3,2,1,0; the advance coincides with the 127→0 wrap.
- **Simultaneous events:** a forced wrap advance takes priority over any fade step. A skip edge arriving in the same cycle as a frame event sets `pend` for the next frame event.

## Timing
- All outputs are registered. Changes caused by a frame event are visible in the cycle after the frame_start cycle.
- `beat`, `envelope` and `beats_1_3` are registered alongside `frame`, so they are never out of phase with it.
- Skip latency: `pend` is set 3 clocks after `skip` rises. Action occurs at the next frame event.
- A mid-operation reset restores all reset values on the next edge, regardless of state, hold, or pend.

## Configuration
- `SEQ_FADE_EN` defined: the fade state machine operates as described above.
- `SEQ_FADE_EN` undefined:
  - The FADE states and `sc` are removed.
  - `fade` is constant 3 after leaving WAIT (0 in WAIT).
  - WAIT goes to RUN on the first frame event.
  - An advance occurs at the wrap, or at any frame event where `pend`=1.
  - `part_start` behaviour is unchanged.

## Test plan
- **Reset then frame events, FADE_STEP=2:**
  - After 1 event, `fade`=0 and `frame`=0.
  - `fade` becomes 1, 2, 3 after 2, 4, 6 further events.
  - `envelope`=31 at `frame`=0 and 1 at `frame`=15.
- **Natural run:**
  - `fade` drops 3→2 at `frame`=122, and reaches 0 at `frame`=126.
  - At the next wrap, `part` becomes 1, `frame`=0, and `part_start` pulses exactly once.
- **Skip pulse at `frame`=40 in RUN:**
  - The next frame event enters FADE_OUT.
  - `part` advances 8 events later with `frame`=0.
  - A second skip during FADE_OUT has no effect.
- **Hold high across 10 frame_start pulses:** `frame`, `fade` and `part` are unchanged. A skip during hold is honoured at the first frame event after hold falls.
- **Wrap with LAST_PART=7, START_PART=2:** advance from part 7 yields 2. Apply reset at `frame`=60 of part 5: the next cycle shows `part`=2, `frame`=0, `fade`=0.
- **Without SEQ_FADE_EN:**
  - `fade`=3 from the first frame event onward.
  - A skip edge advances `part` at the next frame event with no fade frames.

Source files
------------

// File: rtl/demo_part_sequencer_if.sv
// Signal bundle between the demo part sequencer, the sync generator / buttons that feed it,
// and the pixel datapath and colour stage that consume its outputs.
interface demo_part_sequencer_if;
  logic       frame_start;
  logic       skip;
  logic       hold;
  logic [2:0] part;
  logic [6:0] frame;
  logic [2:0] beat;
  logic [4:0] envelope;
  logic       beats_1_3;
  logic [1:0] fade;
  logic       part_start;

  modport master (
    output frame_start, skip, hold,
    input  part, frame, beat, envelope, beats_1_3, fade, part_start
  );

  modport slave (
    input  frame_start, skip, hold,
    output part, frame, beat, envelope, beats_1_3, fade, part_start
  );
endinterface

// File: rtl/demo_part_sequencer.sv
// Frame-rate demo scheduler: part index, frame counter, beat timing and fade level.
// Define SEQ_FADE_EN to build the fade-in/fade-out state machine; otherwise fade is 0 or 3.
module demo_part_sequencer #(
  parameter int unsigned FADE_STEP  = 2,
  parameter int unsigned START_PART = 0,
  parameter int unsigned LAST_PART  = 7
) (
  input logic                  clk,
  input logic                  rst_n,
  demo_part_sequencer_if.slave bus
);

  localparam logic [2:0] StartPart = 3'(START_PART);
  localparam logic [2:0] LastPart  = 3'(LAST_PART);

  if (FADE_STEP < 1 || FADE_STEP > 8 || START_PART > LAST_PART || LAST_PART > 7)
  begin : g_param_check
    $error("demo_part_sequencer: illegal parameter set");
  end

`ifdef SEQ_FADE_EN
  typedef enum logic [1:0] {StWait, StFadeIn, StRun, StFadeOut} state_e;
  localparam logic [2:0] ScLast       = 3'(FADE_STEP - 1);
  localparam logic [6:0] FadeOutFrame = 7'(128 - 4 * FADE_STEP);
`else
  typedef enum logic [0:0] {StWait, StRun} state_e;
`endif

  state_e     state_q, state_d;
  logic [2:0] part_q, part_d, part_next;
  logic [6:0] frame_q, frame_d, frame_inc;
  logic [1:0] fade_q, fade_d;
  logic       part_start_q, part_start_d;
  logic [2:0] beat_q;
  logic [4:0] envelope_q;
  logic       beats_1_3_q;
  logic       skip_s1_q, skip_s2_q, skip_s3_q, skip_rise;
  logic       pend_q, pend_d;
  logic       frame_ev, wrap, advance;

  assign frame_ev  = bus.frame_start & ~bus.hold;
  assign frame_inc = frame_q + 7'd1;
  assign wrap      = (frame_q == 7'd127);
  assign part_next = (part_q == LastPart) ? StartPart : part_q + 3'd1;
  assign skip_rise = skip_s2_q & ~skip_s3_q;

  // A new edge wins over the clear so it is kept for the following frame event.
  assign pend_d = skip_rise | (pend_q & ~frame_ev);

`ifdef SEQ_FADE_EN
  logic [2:0] sc_q, sc_d;
  logic       step_exp;

  assign step_exp = (sc_q == ScLast);

  always_comb begin
    state_d      = state_q;
    part_d       = part_q;
    frame_d      = frame_q;
    fade_d       = fade_q;
    sc_d         = sc_q;
    part_start_d = 1'b0;
    advance      = 1'b0;
    if (frame_ev) begin
      sc_d = step_exp ? 3'd0 : sc_q + 3'd1;
      if (state_q == StWait) begin
        state_d = StFadeIn;
        fade_d  = 2'd0;
        sc_d    = 3'd0;
      end else if (wrap) begin
        advance = 1'b1;
      end else begin
        frame_d = frame_inc;
        case (state_q)
          StFadeIn, StRun: begin
            // Fade-out entry outranks a fade-in step; the current level is kept.
            if (pend_q || frame_inc == FadeOutFrame) begin
              state_d = StFadeOut;
              sc_d    = 3'd0;
            end else if (state_q == StFadeIn && step_exp) begin
              fade_d = fade_q + 2'd1;
              if (fade_q == 2'd2) begin
                state_d = StRun;
                sc_d    = 3'd0;
              end
            end
          end
          StFadeOut: begin
            if (step_exp) begin
              if (fade_q == 2'd0) begin
                advance = 1'b1;
              end else begin
                fade_d = fade_q - 2'd1;
              end
            end
          end
          default: ;
        endcase
      end
      if (advance) begin
        part_d       = part_next;
        frame_d      = 7'd0;
        fade_d       = 2'd0;
        state_d      = StFadeIn;
        sc_d         = 3'd0;
        part_start_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sc_q <= 3'd0;
    end else begin
      sc_q <= sc_d;
    end
  end
`else
  always_comb begin
    state_d      = state_q;
    part_d       = part_q;
    frame_d      = frame_q;
    fade_d       = fade_q;
    part_start_d = 1'b0;
    advance      = 1'b0;
    if (frame_ev) begin
      if (state_q == StWait) begin
        state_d = StRun;
        fade_d  = 2'd3;
      end else if (wrap || pend_q) begin
        advance = 1'b1;
      end else begin
        frame_d = frame_inc;
      end
      if (advance) begin
        part_d       = part_next;
        frame_d      = 7'd0;
        state_d      = StRun;
        part_start_d = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StWait;
      part_q       <= StartPart;
      frame_q      <= 7'd0;
      fade_q       <= 2'd0;
      part_start_q <= 1'b0;
      beat_q       <= 3'd0;
      envelope_q   <= 5'd31;
      beats_1_3_q  <= 1'b0;
      skip_s1_q    <= 1'b0;
      skip_s2_q    <= 1'b0;
      skip_s3_q    <= 1'b0;
      pend_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      part_q       <= part_d;
      frame_q      <= frame_d;
      fade_q       <= fade_d;
      part_start_q <= part_start_d;
      // Beat timing is registered from the next frame value so it never lags the counter.
      beat_q       <= frame_d[6:4];
      envelope_q   <= 5'd31 - {frame_d[3:0], 1'b0};
      beats_1_3_q  <= (frame_d[5:4] == 2'b10);
      skip_s1_q    <= bus.skip;
      skip_s2_q    <= skip_s1_q;
      skip_s3_q    <= skip_s2_q;
      pend_q       <= pend_d;
    end
  end

  assign bus.part       = part_q;
  assign bus.frame      = frame_q;
  assign bus.beat       = beat_q;
  assign bus.envelope   = envelope_q;
  assign bus.beats_1_3  = beats_1_3_q;
  assign bus.fade       = fade_q;
  assign bus.part_start = part_start_q;

endmodule

// File: tb/tb_demo_part_sequencer.sv
// Bench for demo_part_sequencer: vector table, directed multi-cycle sequences and a
// randomized run against a behavioural model. Honours SEQ_FADE_EN like the design.
module tb_demo_part_sequencer;
  localparam int FS = 2;
  localparam int SP = 2;
  localparam int LP = 7;
`ifdef SEQ_FADE_EN
  localparam bit FadeEn = 1'b1;
`else
  localparam bit FadeEn = 1'b0;
`endif
  localparam int FadeOn = FadeEn ? 0 : 3;  // fade right after a part starts

  logic clk = 1'b0;
  logic rst_n;
  demo_part_sequencer_if bus ();

  demo_part_sequencer #(
    .FADE_STEP (FS),
    .START_PART(SP),
    .LAST_PART (LP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ps_cnt  = 0;

  // Behavioural model: n counts frame events since the current phase began.
  typedef struct {
    bit       started;
    int       part;
    int       frame;
    bit       out;
    int       n;
    int       base;
    bit       pend;
    bit [2:0] h;
    bit       ps;
  } m_t;

  m_t m = '{default: 0};

  function automatic int fade_of(m_t c);
    if (!c.started) return 0;
`ifdef SEQ_FADE_EN
    if (c.out) return c.base - c.n / FS;
    return (c.n / FS > 3) ? 3 : c.n / FS;
`else
    return 3;
`endif
  endfunction

  function automatic m_t model_next(m_t c, bit rst, bit fs, bit sk, bit hd);
    m_t r;
    bit ev, adv, rise;
    r = c;
    r.ps = 1'b0;
    if (!rst) begin
      r = '{default: 0};
      r.part = SP;
      return r;
    end
    rise   = c.h[1] & ~c.h[2];
    r.h    = {c.h[1:0], sk};
    ev     = fs & !hd;
    r.pend = rise | (c.pend & !ev);
    adv    = 1'b0;
    if (ev) begin
      if (!c.started) begin
        r.started = 1'b1;
        r.n = 0;
      end else if (c.frame == 127) begin
        adv = 1'b1;
`ifdef SEQ_FADE_EN
      end else begin
        r.frame = c.frame + 1;
        if (!c.out) begin
          if (c.pend || r.frame == 128 - 4 * FS) begin
            r.out  = 1'b1;
            r.base = fade_of(c);
            r.n    = 0;
          end else begin
            r.n = c.n + 1;
          end
        end else begin
          r.n = c.n + 1;
          if (r.n == (c.base + 1) * FS) adv = 1'b1;
        end
      end
`else
      end else if (c.pend) begin
        adv = 1'b1;
      end else begin
        r.frame = c.frame + 1;
      end
`endif
      if (adv) begin
        r.part  = (c.part == LP) ? SP : c.part + 1;
        r.frame = 0;
        r.out   = 1'b0;
        r.n     = 0;
        r.ps    = 1'b1;
      end
    end
    return r;
  endfunction

  always @(posedge clk) m <= model_next(m, rst_n, bus.frame_start, bus.skip, bus.hold);

  task automatic check_out(input string name, input int p, input int f, input int fd,
                           input bit ps);
    int e_env, e_beat;
    bit e_b13;
    e_env  = 31 - 2 * (f % 16);
    e_beat = f / 16;
    e_b13  = ((f / 16) % 4) == 2;
    n_tests++;
    if (bus.part !== 3'(p) || bus.frame !== 7'(f) || bus.beat !== 3'(e_beat) ||
        bus.envelope !== 5'(e_env) || bus.beats_1_3 !== e_b13 || bus.fade !== 2'(fd) ||
        bus.part_start !== ps) begin
      n_fail++;
      $display("FAIL %s: got part=%0d frame=%0d beat=%0d env=%0d b13=%0b fade=%0d ps=%0b, want part=%0d frame=%0d beat=%0d env=%0d b13=%0b fade=%0d ps=%0b",
               name, bus.part, bus.frame, bus.beat, bus.envelope, bus.beats_1_3, bus.fade,
               bus.part_start, p, f, e_beat, e_env, e_b13, fd, ps);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic step(input bit fs, input bit sk, input bit hd);
    bus.frame_start = fs;
    bus.skip        = sk;
    bus.hold        = hd;
    @(negedge clk);
    if (bus.part_start) ps_cnt++;
  endtask

  task automatic events(input int k);
    repeat (k) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  // Pulse skip, then feed frame events until the part changes (bounded).
  task automatic skip_advance(input int want_part);
    bit seen;
    seen = 1'b0;
    repeat (3) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (bus.part_start) seen = 1'b1;
    end
    check_int($sformatf("skip_adv_seen_%0d", want_part), int'(seen), 1);
    check_out($sformatf("skip_adv_%0d", want_part), want_part, 0, FadeOn, 1'b1);
  endtask

  typedef struct {
    bit rst;
    bit fs;
    bit sk;
    bit hd;
    int part;
    int frame;
    int fade;
    bit ps;
  } vec_t;

  vec_t tbl[15];

  initial begin
    bit fs, sk, hd, rst;
`ifdef SEQ_FADE_EN
    tbl = '{'{0, 0, 0, 0, 2, 0, 0, 0}, '{1, 0, 0, 0, 2, 0, 0, 0}, '{1, 1, 0, 0, 2, 0, 0, 0},
            '{1, 1, 0, 0, 2, 1, 0, 0}, '{1, 0, 0, 0, 2, 1, 0, 0}, '{1, 1, 0, 1, 2, 1, 0, 0},
            '{1, 1, 0, 0, 2, 2, 1, 0}, '{1, 0, 1, 0, 2, 2, 1, 0}, '{1, 0, 1, 0, 2, 2, 1, 0},
            '{1, 1, 1, 0, 2, 3, 1, 0}, '{1, 1, 1, 0, 2, 4, 1, 0}, '{1, 0, 1, 0, 2, 4, 1, 0},
            '{1, 1, 1, 0, 2, 5, 1, 0}, '{1, 1, 0, 1, 2, 5, 1, 0}, '{0, 0, 0, 0, 2, 0, 0, 0}};
`else
    tbl = '{'{0, 0, 0, 0, 2, 0, 0, 0}, '{1, 0, 0, 0, 2, 0, 0, 0}, '{1, 1, 0, 0, 2, 0, 3, 0},
            '{1, 1, 0, 0, 2, 1, 3, 0}, '{1, 0, 0, 0, 2, 1, 3, 0}, '{1, 1, 0, 1, 2, 1, 3, 0},
            '{1, 1, 0, 0, 2, 2, 3, 0}, '{1, 0, 1, 0, 2, 2, 3, 0}, '{1, 0, 1, 0, 2, 2, 3, 0},
            '{1, 1, 1, 0, 2, 3, 3, 0}, '{1, 1, 1, 0, 3, 0, 3, 1}, '{1, 0, 1, 0, 3, 0, 3, 0},
            '{1, 1, 1, 0, 3, 1, 3, 0}, '{1, 1, 0, 1, 3, 1, 3, 0}, '{0, 0, 0, 0, 2, 0, 0, 0}};
`endif
    rst_n           = 1'b0;
    bus.frame_start = 1'b0;
    bus.skip        = 1'b0;
    bus.hold        = 1'b0;

    for (int i = 0; i < 15; i++) begin
      rst_n = tbl[i].rst;
      step(tbl[i].fs, tbl[i].sk, tbl[i].hd);
      check_out($sformatf("vec%0d", i), tbl[i].part, tbl[i].frame, tbl[i].fade, tbl[i].ps);
    end
    rst_n = 1'b1;

    // Natural run through a full part and the forced wrap advance.
    do_reset();
    check_out("run_reset", SP, 0, 0, 1'b0);
    events(1);
    check_out("run_first_event", SP, 0, FadeOn, 1'b0);
    events(15);
    check_out("run_frame15", SP, 15, 3, 1'b0);
    events(106);
    check_out("run_frame121", SP, 121, 3, 1'b0);
    events(1);
    check_out("run_frame122", SP, 122, FadeEn ? 2 : 3, 1'b0);
    events(4);
    check_out("run_frame126", SP, 126, FadeEn ? 0 : 3, 1'b0);
    events(1);
    check_out("run_frame127", SP, 127, FadeEn ? 0 : 3, 1'b0);
    ps_cnt = 0;
    events(1);
    check_out("run_wrap", SP + 1, 0, FadeOn, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check_out("run_after_wrap", SP + 1, 0, FadeOn, 1'b0);
    check_int("run_part_start_once", ps_cnt, 1);

    // Skip at frame 40 of a running part.
    events(40);
    check_out("skip_frame40", SP + 1, 40, 3, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    events(1);
`ifdef SEQ_FADE_EN
    check_out("skip_enter_fadeout", SP + 1, 41, 3, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    events(7);
    check_out("skip_fadeout_end", SP + 1, 48, 0, 1'b0);
    events(1);
    check_out("skip_advance", SP + 2, 0, 0, 1'b1);
`else
    check_out("skip_advance", SP + 2, 0, 3, 1'b1);
`endif

    // Hold freezes state across frame_start pulses; a skip during hold is kept.
    events(10);
    check_out("hold_before", SP + 2, 10, 3, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, i >= 3, 1'b1);
      step(1'b0, i >= 3, 1'b1);
    end
    check_out("hold_frozen", SP + 2, 10, 3, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    events(1);
`ifdef SEQ_FADE_EN
    check_out("hold_release", SP + 2, 11, 3, 1'b0);
`else
    check_out("hold_release", SP + 3, 0, 3, 1'b1);
`endif

    // Part wrap LAST_PART -> START_PART, then reset in the middle of part 5.
    do_reset();
    check_out("wrap_reset", SP, 0, 0, 1'b0);
    events(1);
    for (int p = SP + 1; p <= LP; p++) skip_advance(p);
    skip_advance(SP);
    for (int p = SP + 1; p <= 5; p++) skip_advance(p);
    events(60);
    check_out("mid_part5", 5, 60, 3, 1'b0);
    rst_n = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    check_out("mid_reset", SP, 0, 0, 1'b0);

    // Randomized run against the model.
    fs = 1'b0;
    sk = 1'b0;
    hd = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      fs  = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 29) == 0) sk = ~sk;
      if ($urandom_range(0, 15) == 0) hd = ~hd;
      rst = ($urandom_range(0, 1499) != 0);
      rst_n = rst;
      step(fs, sk, hd);
      check_out($sformatf("rand%0d", i), m.part, m.frame, fade_of(m), m.ps);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
